// File: rtl/controller_pkg.sv
// Shared encodings for the multicycle controller: states, opcodes, funct codes,
// ALU-op classes, ALU control values and the per-state control word.
package controller_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_RTYPEEX,
    S_RTYPEWB,
    S_BEQEX,
    S_ADDIEX,
    S_ADDIWB,
    S_JEX
  } state_t;

  localparam int unsigned OP_W    = 6;
  localparam int unsigned FUNCT_W = 6;
  localparam int unsigned ALUOP_W = 2;
  localparam int unsigned ALUC_W  = 3;

  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;

  localparam logic [FUNCT_W-1:0] FUNCT_ADD = 6'b100000;
  localparam logic [FUNCT_W-1:0] FUNCT_SUB = 6'b100010;
  localparam logic [FUNCT_W-1:0] FUNCT_AND = 6'b100100;
  localparam logic [FUNCT_W-1:0] FUNCT_OR  = 6'b100101;
  localparam logic [FUNCT_W-1:0] FUNCT_SLT = 6'b101010;

  localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 2'b00;
  localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 2'b01;
  localparam logic [ALUOP_W-1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [ALUOP_W-1:0] ALUOP_ADD2  = 2'b11;

  localparam logic [ALUC_W-1:0] ALUC_AND = 3'b000;
  localparam logic [ALUC_W-1:0] ALUC_OR  = 3'b001;
  localparam logic [ALUC_W-1:0] ALUC_ADD = 3'b010;
  localparam logic [ALUC_W-1:0] ALUC_SUB = 3'b110;
  localparam logic [ALUC_W-1:0] ALUC_SLT = 3'b111;

  typedef struct packed {
    logic               memwrite;
    logic               irwrite;
    logic               regwrite;
    logic               alusrca;
    logic               iord;
    logic               memtoreg;
    logic               regdst;
    logic [1:0]         alusrcb;
    logic [1:0]         pcsrc;
    logic [ALUOP_W-1:0] aluop;
    logic               pcwrite;
    logic               branch;
  } ctl_t;

endpackage

// File: rtl/controller_aludec.sv
// ALU decoder: maps the FSM's ALU-op class and the R-type funct field to an ALU operation.
module aludec
  import controller_pkg::*;
(
  input  logic [ALUOP_W-1:0] aluop,
  input  logic [FUNCT_W-1:0] funct,
  output logic [ALUC_W-1:0]  alucontrol
);

  always_comb begin
    alucontrol = ALUC_ADD;
    case (aluop)
      ALUOP_ADD:  alucontrol = ALUC_ADD;
      ALUOP_SUB:  alucontrol = ALUC_SUB;
      ALUOP_ADD2: alucontrol = ALUC_ADD;
      default: begin
        case (funct)
          FUNCT_ADD: alucontrol = ALUC_ADD;
          FUNCT_SUB: alucontrol = ALUC_SUB;
          FUNCT_AND: alucontrol = ALUC_AND;
          FUNCT_OR:  alucontrol = ALUC_OR;
          FUNCT_SLT: alucontrol = ALUC_SLT;
          default:   alucontrol = ALUC_ADD;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/controller.sv
// Multicycle Moore controller: state register plus a control word registered
// alongside it, so every strobe except pcen comes straight from a flop.
module controller
  import controller_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [OP_W-1:0]    op,
  input  logic [FUNCT_W-1:0] funct,
  input  logic               zero,
  output logic               pcen,
  output logic               memwrite,
  output logic               irwrite,
  output logic               regwrite,
  output logic               alusrca,
  output logic               iord,
  output logic               memtoreg,
  output logic               regdst,
  output logic [1:0]         alusrcb,
  output logic [1:0]         pcsrc,
  output logic [ALUC_W-1:0]  alucontrol
);

  state_t state;
  state_t state_nxt;
  ctl_t   ctl;

  function automatic state_t next_state(state_t s, logic [OP_W-1:0] o);
    state_t n;
    n = S_FETCH;
    case (s)
      S_FETCH:  n = S_DECODE;
      S_DECODE: begin
        case (o)
          OP_LW, OP_SW: n = S_MEMADR;
          OP_RTYPE:     n = S_RTYPEEX;
          OP_BEQ:       n = S_BEQEX;
          OP_ADDI:      n = S_ADDIEX;
          OP_J:         n = S_JEX;
          default:      n = S_FETCH;
        endcase
      end
      S_MEMADR:  n = (o == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   n = S_MEMWB;
      S_RTYPEEX: n = S_RTYPEWB;
      S_ADDIEX:  n = S_ADDIWB;
      default:   n = S_FETCH;
    endcase
    return n;
  endfunction

  function automatic ctl_t decode_ctl(state_t s);
    ctl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.alusrcb = 2'b01;
        c.irwrite = 1'b1;
        c.pcwrite = 1'b1;
      end
      S_DECODE:  c.alusrcb = 2'b11;
      S_MEMADR: begin
        c.alusrca = 1'b1;
        c.alusrcb = 2'b10;
      end
      S_MEMRD:   c.iord = 1'b1;
      S_MEMWB: begin
        c.memtoreg = 1'b1;
        c.regwrite = 1'b1;
      end
      S_MEMWR: begin
        c.iord     = 1'b1;
        c.memwrite = 1'b1;
      end
      S_RTYPEEX: begin
        c.alusrca = 1'b1;
        c.aluop   = ALUOP_FUNCT;
      end
      S_RTYPEWB: begin
        c.regdst   = 1'b1;
        c.regwrite = 1'b1;
      end
      S_BEQEX: begin
        c.alusrca = 1'b1;
        c.aluop   = ALUOP_SUB;
        c.pcsrc   = 2'b01;
        c.branch  = 1'b1;
      end
      S_ADDIEX: begin
        c.alusrca = 1'b1;
        c.alusrcb = 2'b10;
      end
      S_ADDIWB:  c.regwrite = 1'b1;
      S_JEX: begin
        c.pcsrc   = 2'b10;
        c.pcwrite = 1'b1;
      end
      default:   c = '0;
    endcase
    return c;
  endfunction

  assign state_nxt = next_state(state, op);

  // Control word is loaded from the state being entered, keeping it in step with state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_FETCH;
      ctl   <= decode_ctl(S_FETCH);
    end else begin
      state <= state_nxt;
      ctl   <= decode_ctl(state_nxt);
    end
  end

  assign pcen     = ctl.pcwrite | (ctl.branch & zero);
  assign memwrite = ctl.memwrite;
  assign irwrite  = ctl.irwrite;
  assign regwrite = ctl.regwrite;
  assign alusrca  = ctl.alusrca;
  assign iord     = ctl.iord;
  assign memtoreg = ctl.memtoreg;
  assign regdst   = ctl.regdst;
  assign alusrcb  = ctl.alusrcb;
  assign pcsrc    = ctl.pcsrc;

  aludec u_aludec (
    .aluop      (ctl.aluop),
    .funct      (funct),
    .alucontrol (alucontrol)
  );

endmodule

// File: tb/tb_controller.sv
// Self-checking bench for controller: constant vector table, reset corner sequences,
// and random instruction streams checked against a per-instruction cycle model.
module tb_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       pcen, memwrite, irwrite, regwrite, alusrca, iord, memtoreg, regdst;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic [14:0] got;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  controller dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .pcen(pcen), .memwrite(memwrite), .irwrite(irwrite), .regwrite(regwrite),
    .alusrca(alusrca), .iord(iord), .memtoreg(memtoreg), .regdst(regdst),
    .alusrcb(alusrcb), .pcsrc(pcsrc), .alucontrol(alucontrol)
  );

  assign got = {pcen, memwrite, irwrite, regwrite, alusrca, iord, memtoreg, regdst,
                alusrcb, pcsrc, alucontrol};

  function automatic logic [14:0] mk(input logic pe, mw, irw, rw, asa, io, m2r, rd,
                                     input logic [1:0] asb, ps, input logic [2:0] ac);
    return {pe, mw, irw, rw, asa, io, m2r, rd, asb, ps, ac};
  endfunction

  function automatic int latency(input logic [5:0] o);
    case (o)
      6'b100011: return 5;
      6'b101011, 6'b000000, 6'b001000: return 4;
      6'b000100, 6'b000010: return 3;
      default: return 2;
    endcase
  endfunction

  function automatic logic [2:0] rtype_alu(input logic [5:0] f);
    case (f)
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  // Expected outputs in cycle k of an instruction (k=0 is its fetch).
  function automatic logic [14:0] exp_out(input logic [5:0] o, f, input logic z, input int k);
    if (k == 0) return mk(1,0,1,0,0,0,0,0,2'b01,2'b00,3'b010);
    if (k == 1) return mk(0,0,0,0,0,0,0,0,2'b11,2'b00,3'b010);
    case (o)
      6'b100011: begin
        if (k == 2) return mk(0,0,0,0,1,0,0,0,2'b10,2'b00,3'b010);
        if (k == 3) return mk(0,0,0,0,0,1,0,0,2'b00,2'b00,3'b010);
        return mk(0,0,0,1,0,0,1,0,2'b00,2'b00,3'b010);
      end
      6'b101011: begin
        if (k == 2) return mk(0,0,0,0,1,0,0,0,2'b10,2'b00,3'b010);
        return mk(0,1,0,0,0,1,0,0,2'b00,2'b00,3'b010);
      end
      6'b000000: begin
        if (k == 2) return mk(0,0,0,0,1,0,0,0,2'b00,2'b00,rtype_alu(f));
        return mk(0,0,0,1,0,0,0,1,2'b00,2'b00,3'b010);
      end
      6'b000100: return mk(z,0,0,0,1,0,0,0,2'b00,2'b01,3'b110);
      6'b001000: begin
        if (k == 2) return mk(0,0,0,0,1,0,0,0,2'b10,2'b00,3'b010);
        return mk(0,0,0,1,0,0,0,0,2'b00,2'b00,3'b010);
      end
      6'b000010: return mk(1,0,0,0,0,0,0,0,2'b00,2'b10,3'b010);
      default:   return mk(1,0,1,0,0,0,0,0,2'b01,2'b00,3'b010);
    endcase
  endfunction

  task automatic check(input string name, input logic [14:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%b required=%b", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic run_instr(input logic [5:0] o, f, input logic z);
    op = o; funct = f; zero = z;
    for (int k = 0; k < latency(o); k++) begin
      check($sformatf("rand op=%b f=%b z=%0d k=%0d", o, f, z, k), exp_out(o, f, z, k));
      step();
    end
  endtask

  typedef struct {
    string       name;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        zero;
    int          k;
    logic [14:0] exp;
  } vec_t;

  vec_t tbl [15];
  logic [5:0] ops [7];
  logic [5:0] fns [6];

  initial begin
    reset = 1'b1; op = '0; funct = '0; zero = 1'b0;
    tbl[0]  = '{"lw_decode", 6'b100011, 6'h00, 1'b0, 1, mk(0,0,0,0,0,0,0,0,2'b11,2'b00,3'b010)};
    tbl[1]  = '{"lw_memadr", 6'b100011, 6'h00, 1'b0, 2, mk(0,0,0,0,1,0,0,0,2'b10,2'b00,3'b010)};
    tbl[2]  = '{"lw_memrd",  6'b100011, 6'h00, 1'b0, 3, mk(0,0,0,0,0,1,0,0,2'b00,2'b00,3'b010)};
    tbl[3]  = '{"lw_memwb",  6'b100011, 6'h00, 1'b0, 4, mk(0,0,0,1,0,0,1,0,2'b00,2'b00,3'b010)};
    tbl[4]  = '{"lw_refetch",6'b100011, 6'h00, 1'b0, 5, mk(1,0,1,0,0,0,0,0,2'b01,2'b00,3'b010)};
    tbl[5]  = '{"sw_memwr",  6'b101011, 6'h00, 1'b0, 3, mk(0,1,0,0,0,1,0,0,2'b00,2'b00,3'b010)};
    tbl[6]  = '{"r_sub",     6'b000000, 6'b100010, 1'b0, 2, mk(0,0,0,0,1,0,0,0,2'b00,2'b00,3'b110)};
    tbl[7]  = '{"r_and",     6'b000000, 6'b100100, 1'b0, 2, mk(0,0,0,0,1,0,0,0,2'b00,2'b00,3'b000)};
    tbl[8]  = '{"r_or",      6'b000000, 6'b100101, 1'b0, 2, mk(0,0,0,0,1,0,0,0,2'b00,2'b00,3'b001)};
    tbl[9]  = '{"r_slt",     6'b000000, 6'b101010, 1'b0, 2, mk(0,0,0,0,1,0,0,0,2'b00,2'b00,3'b111)};
    tbl[10] = '{"r_wb",      6'b000000, 6'b101010, 1'b0, 3, mk(0,0,0,1,0,0,0,1,2'b00,2'b00,3'b010)};
    tbl[11] = '{"beq_taken", 6'b000100, 6'h00, 1'b1, 2, mk(1,0,0,0,1,0,0,0,2'b00,2'b01,3'b110)};
    tbl[12] = '{"beq_not",   6'b000100, 6'h00, 1'b0, 2, mk(0,0,0,0,1,0,0,0,2'b00,2'b01,3'b110)};
    tbl[13] = '{"j_ex",      6'b000010, 6'h00, 1'b0, 2, mk(1,0,0,0,0,0,0,0,2'b00,2'b10,3'b010)};
    tbl[14] = '{"addi_wb",   6'b001000, 6'h00, 1'b0, 3, mk(0,0,0,1,0,0,0,0,2'b00,2'b00,3'b010)};

    step();
    step();
    reset = 1'b0;
    check("reset_fetch", mk(1,0,1,0,0,0,0,0,2'b01,2'b00,3'b010));

    foreach (tbl[i]) begin
      op = tbl[i].op; funct = tbl[i].funct; zero = tbl[i].zero;
      do_reset();
      for (int c = 0; c < tbl[i].k; c++) step();
      check(tbl[i].name, tbl[i].exp);
    end

    // Unknown opcode: FETCH, DECODE, back to FETCH.
    op = 6'b111111; funct = '0; zero = 1'b1;
    do_reset();
    step();
    check("illegal_decode", mk(0,0,0,0,0,0,0,0,2'b11,2'b00,3'b010));
    step();
    check("illegal_refetch", mk(1,0,1,0,0,0,0,0,2'b01,2'b00,3'b010));

    // Reset asserted mid-instruction aborts at that edge.
    op = 6'b100011; zero = 1'b0;
    do_reset();
    step(); step(); step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("abort_reset", mk(1,0,1,0,0,0,0,0,2'b01,2'b00,3'b010));

    // Reset pulsed between edges has no effect.
    op = 6'b101011;
    step();
    reset = 1'b1;
    #3;
    reset = 1'b0;
    step();
    check("glitch_reset", mk(0,0,0,0,1,0,0,0,2'b10,2'b00,3'b010));
    step();
    check("sw_after_glitch", mk(0,1,0,0,0,1,0,0,2'b00,2'b00,3'b010));

    // Random instruction stream from a clean FETCH.
    ops[0] = 6'b100011; ops[1] = 6'b101011; ops[2] = 6'b000000; ops[3] = 6'b000100;
    ops[4] = 6'b001000; ops[5] = 6'b000010; ops[6] = 6'b000000;
    fns[0] = 6'b100000; fns[1] = 6'b100010; fns[2] = 6'b100100;
    fns[3] = 6'b100101; fns[4] = 6'b101010; fns[5] = 6'b000000;
    do_reset();
    for (int n = 0; n < 120; n++) begin
      logic [5:0] o, f;
      logic z;
      int r;
      r = int'($urandom_range(0, 8));
      o = (r < 7) ? ops[r] : 6'($urandom);
      r = int'($urandom_range(0, 6));
      f = (r < 6) ? fns[r] : 6'($urandom);
      z = 1'($urandom);
      run_instr(o, f, z);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/controller.md
CONTROLLER -- requirements
Module: controller

Interface
REQ-001 Parameters: none.
REQ-002 clk  input  1  rising-edge clock, sole clock.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 op  input  6  instruction opcode, instr[31:26].
REQ-005 funct  input  6  R-type function field, instr[5:0].
REQ-006 zero  input  1  ALU result-is-zero flag.
REQ-007 pcen  output  1  PC register enable.
REQ-008 memwrite  output  1  memory write enable.
REQ-009 irwrite  output  1  instruction register enable.
REQ-010 regwrite  output  1  register file write enable.
REQ-011 alusrca  output  1  ALU A select: 0=PC, 1=A register.
REQ-012 iord  output  1  memory address select: 0=PC, 1=ALUOut.
REQ-013 memtoreg  output  1  register write-data select: 0=ALUOut, 1=Data.
REQ-014 regdst  output  1  destination register select: 0=rt, 1=rd.
REQ-015 alusrcb  output  2  ALU B select: 00=B, 01=constant 4, 10=SignImm, 11=SignImm<<2.
REQ-016 pcsrc  output  2  next-PC select: 00=ALUResult, 01=ALUOut, 10=jump target.
REQ-017 alucontrol  output  3  ALU operation: 000 AND, 001 OR, 010 add, 110 sub, 111 SLT.

Function
REQ-018 The controller is a Moore FSM; every output except pcen depends only on the current state, with internal aluop[1:0], pcwrite and branch signals.
REQ-019 Opcodes: LW 100011, SW 101011, RTYPE 000000, BEQ 000100, ADDI 001000, J 000010.
REQ-020 States and nondefault outputs; every unlisted output is 0 and alusrcb/pcsrc/aluop default to 00:
- FETCH: alusrcb=01, irwrite=1, pcwrite=1.
- DECODE: alusrcb=11.
- MEMADR: alusrca=1, alusrcb=10.
- MEMRD: iord=1.
- MEMWB: memtoreg=1, regwrite=1.
- MEMWR: iord=1, memwrite=1.
- RTYPEEX: alusrca=1, aluop=10.
- RTYPEWB: regdst=1, regwrite=1.
- BEQEX: alusrca=1, aluop=01, pcsrc=01, branch=1.
- ADDIEX: alusrca=1, alusrcb=10.
- ADDIWB: regwrite=1.
- JEX: pcsrc=10, pcwrite=1.
REQ-021 Transitions:
- FETCH goes to DECODE.
- DECODE goes to MEMADR (LW/SW), RTYPEEX, BEQEX, ADDIEX or JEX according to op.
- MEMADR goes to MEMRD for LW, else MEMWR.
- MEMRD goes to MEMWB.
- RTYPEEX goes to RTYPEWB.
- ADDIEX goes to ADDIWB.
- MEMWB, MEMWR, RTYPEWB, BEQEX, ADDIWB and JEX go to FETCH.
REQ-022 An unrecognised op in DECODE returns the FSM to FETCH, with no write strobes asserted.
REQ-023 pcen = pcwrite OR (branch AND zero), combinational, so zero is sampled in the BEQEX cycle.
REQ-024 ALU decoder mapping to alucontrol:
- aluop 00 gives 010.
- aluop 01 gives 110.
- aluop 11 gives 010.
- aluop 10 decodes funct: 100000 gives 010, 100010 gives 110, 100100 gives 000, 100101 gives 001, 101010 gives 111, any other funct gives 010.
REQ-025 Instruction latency in clocks, including FETCH: LW 5, SW 4, RTYPE 4, ADDI 4, BEQ 3, J 3.

Reset
REQ-026 While reset is high at a rising edge, the state register loads FETCH; reset asserted in any state aborts the instruction at that edge.
REQ-027 Outputs after reset (FETCH): pcen=1, irwrite=1, alusrcb=01, alucontrol=010, all other outputs 0.
REQ-028 No asynchronous behaviour; reset between edges has no effect until the next rising edge.

Structure
REQ-029 A shared package holds the state enum (12 states), the opcode constants, the funct constants, the aluop encodings and the alucontrol encodings.
REQ-030 The ALU decoder is one sub-module, aludec (inputs aluop, funct; output alucontrol); the FSM and output decode stay in controller.

Verification
REQ-031 Reset high for 1 edge -> state FETCH; pcen=1, irwrite=1, alusrcb=01, alucontrol=010, memwrite=0, regwrite=0.
REQ-032 op=100011 (LW) -> FETCH, DECODE, MEMADR (alusrca=1, alusrcb=10), MEMRD (iord=1), MEMWB (regwrite=1, memtoreg=1), then FETCH.
REQ-033 op=101011 (SW) -> memwrite=1 with iord=1 only in the 4th cycle, then FETCH.
REQ-034 op=000000 with funct 100010, 100100, 100101, 101010 -> RTYPEEX alucontrol 110, 000, 001, 111; RTYPEWB has regdst=1, regwrite=1.
REQ-035 op=000100 (BEQ) in BEQEX: zero=1 -> pcen=1, pcsrc=01; zero=0 -> pcen=0; alucontrol=110 in both cases.
REQ-036 op=000010 (J) -> JEX has pcsrc=10, pcen=1; op=001000 (ADDI) -> ADDIWB has regwrite=1, regdst=0; op=111111 -> FETCH, DECODE, FETCH.
